// File: rtl/ahblite_master_arb2.sv
// Two-master AHB-Lite arbiter: zero-latency pass-through for an uncontended master,
// per-master pending register for transfers that lose arbitration or meet a wait state.
module ahblite_master_arb2 #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [1:0]    HTRANS_M0,
    input  logic          HWRITE_M0,
    input  logic [2:0]    HSIZE_M0,
    input  logic [DW-1:0] HWDATA_M0,
    output logic [DW-1:0] HRDATA_M0,
    output logic          HREADY_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M1,
    input  logic [DW-1:0] HWDATA_M1,
    output logic [DW-1:0] HRDATA_M1,
    output logic          HREADY_M1,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY
);

    logic [AW-1:0] w_addr_m [2];
    logic [DW-1:0] w_wdata_m [2];
    logic [2:0]    w_size_m [2];
    logic [1:0]    w_write_m;
    logic [1:0]    w_hready_m;
    logic [1:0]    w_live;
    logic [1:0]    w_req;
    logic          w_has_sel;
    logic          w_sel;
    logic          w_src_pend;
    logic          w_unused;

    logic [1:0]    r_pend, w_pend_d;
    logic [1:0]    r_iss, w_iss_d;
    logic [AW-1:0] r_pend_addr [2];
    logic [AW-1:0] w_pend_addr_d [2];
    logic [1:0]    r_pend_write, w_pend_write_d;
    logic [2:0]    r_pend_size [2];
    logic [2:0]    w_pend_size_d [2];
    logic          r_dvalid, w_dvalid_d;
    logic          r_downer, w_downer_d;
    logic          r_last, w_last_d;
    logic          r_lock, w_lock_d;
    logic          r_lock_m, w_lock_m_d;

    assign w_addr_m[0]  = HADDR_M0;
    assign w_addr_m[1]  = HADDR_M1;
    assign w_wdata_m[0] = HWDATA_M0;
    assign w_wdata_m[1] = HWDATA_M1;
    assign w_size_m[0]  = HSIZE_M0;
    assign w_size_m[1]  = HSIZE_M1;
    assign w_write_m    = {HWRITE_M1, HWRITE_M0};

    // SEQ/BUSY collapse to NONSEQ/IDLE, so only HTRANS[1] matters.
    assign w_unused = HTRANS_M0[0] ^ HTRANS_M1[0];

    // The data-phase owner follows the bus; anyone else is stalled while pending.
    assign w_hready_m[0] = (r_dvalid && !r_downer) ? HREADY : !r_pend[0];
    assign w_hready_m[1] = (r_dvalid &&  r_downer) ? HREADY : !r_pend[1];
    assign w_live        = {HTRANS_M1[1], HTRANS_M0[1]} & w_hready_m;
    assign w_req         = (r_pend & ~r_iss) | w_live;

    assign HREADY_M0 = w_hready_m[0];
    assign HREADY_M1 = w_hready_m[1];
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;
    assign HWDATA    = r_dvalid ? w_wdata_m[r_downer] : '0;

    always_comb begin
        w_has_sel = 1'b0;
        w_sel     = 1'b0;
        if (r_lock) begin
            w_has_sel = 1'b1;
            w_sel     = r_lock_m;
        end else if (w_req[0] && w_req[1]) begin
            w_has_sel = 1'b1;
            w_sel     = !r_last;
        end else if (w_req[0]) begin
            w_has_sel = 1'b1;
            w_sel     = 1'b0;
        end else if (w_req[1]) begin
            w_has_sel = 1'b1;
            w_sel     = 1'b1;
        end
        w_src_pend = r_lock || (r_pend[w_sel] && !r_iss[w_sel]);
    end

    always_comb begin
        HTRANS = 2'b00;
        HADDR  = '0;
        HWRITE = 1'b0;
        HSIZE  = 3'b000;
        if (w_has_sel) begin
            HTRANS = 2'b10;
            if (w_src_pend) begin
                HADDR  = r_pend_addr[w_sel];
                HWRITE = r_pend_write[w_sel];
                HSIZE  = r_pend_size[w_sel];
            end else begin
                HADDR  = w_addr_m[w_sel];
                HWRITE = w_write_m[w_sel];
                HSIZE  = w_size_m[w_sel];
            end
        end
    end

    always_comb begin
        w_pend_d       = r_pend;
        w_iss_d        = r_iss;
        w_pend_addr_d  = r_pend_addr;
        w_pend_write_d = r_pend_write;
        w_pend_size_d  = r_pend_size;
        w_dvalid_d     = r_dvalid;
        w_downer_d     = r_downer;
        w_last_d       = r_last;
        w_lock_d       = r_lock;
        w_lock_m_d     = r_lock_m;

        if (r_dvalid && HREADY && r_pend[r_downer] && r_iss[r_downer]) begin
            w_pend_d[r_downer] = 1'b0;
            w_iss_d[r_downer]  = 1'b0;
        end

        if (w_has_sel) begin
            if (HREADY) begin
                w_dvalid_d = 1'b1;
                w_downer_d = w_sel;
                w_last_d   = w_sel;
                w_lock_d   = 1'b0;
                if (w_src_pend) begin
                    w_iss_d[w_sel] = 1'b1;
                end
            end else begin
                w_lock_d   = 1'b1;
                w_lock_m_d = w_sel;
            end
        end else if (HREADY) begin
            w_dvalid_d = 1'b0;
        end

        // Capture any live transfer not accepted straight onto the bus; this
        // overrides a same-edge completion clear for that master.
        for (int i = 0; i < 2; i++) begin
            if (w_live[i] && !(w_has_sel && (w_sel == 1'(i)) && (w_src_pend || HREADY))) begin
                w_pend_d[i]       = 1'b1;
                w_iss_d[i]        = 1'b0;
                w_pend_addr_d[i]  = w_addr_m[i];
                w_pend_write_d[i] = w_write_m[i];
                w_pend_size_d[i]  = w_size_m[i];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend         <= 2'b00;
            r_iss          <= 2'b00;
            r_pend_addr[0] <= '0;
            r_pend_addr[1] <= '0;
            r_pend_write   <= 2'b00;
            r_pend_size[0] <= 3'b000;
            r_pend_size[1] <= 3'b000;
            r_dvalid       <= 1'b0;
            r_downer       <= 1'b0;
            r_last         <= 1'b1;
            r_lock         <= 1'b0;
            r_lock_m       <= 1'b0;
        end else begin
            r_pend         <= w_pend_d;
            r_iss          <= w_iss_d;
            r_pend_addr[0] <= w_pend_addr_d[0];
            r_pend_addr[1] <= w_pend_addr_d[1];
            r_pend_write   <= w_pend_write_d;
            r_pend_size[0] <= w_pend_size_d[0];
            r_pend_size[1] <= w_pend_size_d[1];
            r_dvalid       <= w_dvalid_d;
            r_downer       <= w_downer_d;
            r_last         <= w_last_d;
            r_lock         <= w_lock_d;
            r_lock_m       <= w_lock_m_d;
        end
    end

endmodule

// File: tb/tb_ahblite_master_arb2.sv
// Directed bench for ahblite_master_arb2: per-cycle vector table plus hand-written
// sequences for burst alternation, mid-transfer reset and a locked wait state.
module tb_ahblite_master_arb2;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [31:0] HRDATA_M0, HRDATA_M1;
    logic        HREADY_M0, HREADY_M1;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;

    int n_checks = 0;
    int n_errors = 0;

    always #5 HCLK = ~HCLK;

    ahblite_master_arb2 #(.AW(32), .DW(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR_M0  (HADDR_M0),
        .HTRANS_M0 (HTRANS_M0),
        .HWRITE_M0 (HWRITE_M0),
        .HSIZE_M0  (HSIZE_M0),
        .HWDATA_M0 (HWDATA_M0),
        .HRDATA_M0 (HRDATA_M0),
        .HREADY_M0 (HREADY_M0),
        .HADDR_M1  (HADDR_M1),
        .HTRANS_M1 (HTRANS_M1),
        .HWRITE_M1 (HWRITE_M1),
        .HSIZE_M1  (HSIZE_M1),
        .HWDATA_M1 (HWDATA_M1),
        .HRDATA_M1 (HRDATA_M1),
        .HREADY_M1 (HREADY_M1),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY)
    );

    typedef struct {
        logic [1:0]  t0;
        logic [31:0] a0;
        logic        w0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        w1;
        logic        rdy;
        logic [31:0] rdata;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_write;
        logic        e_rdy0;
        logic        e_rdy1;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        HTRANS_M0 = 2'b00;
        HADDR_M0  = 32'h0;
        HWRITE_M0 = 1'b0;
        HTRANS_M1 = 2'b00;
        HADDR_M1  = 32'h0;
        HWRITE_M1 = 1'b0;
    endtask

    initial begin
        logic [31:0] a0, a1, exp_addr;
        logic        r0, r1;

        HRESETn   = 1'b0;
        set_idle();
        HSIZE_M0  = 3'd2;
        HSIZE_M1  = 3'd1;
        HWDATA_M0 = 32'h1111_0000;
        HWDATA_M1 = 32'hDEAD_0001;
        HREADY    = 1'b1;
        HRDATA    = 32'h0;

        // Simultaneous NONSEQ after reset (M0 wins, M1 replayed), then M0-only read.
        vecs[0] = '{2'b10, 32'h0000_0004, 1'b0, 2'b10, 32'h4800_0000, 1'b1, 1'b1, 32'h0,
                    2'b10, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[1] = '{2'b00, 32'h0, 1'b0, 2'b10, 32'h4800_0000, 1'b1, 1'b1, 32'h0,
                    2'b10, 32'h4800_0000, 1'b1, 1'b1, 1'b0, 32'h1111_0000};
        vecs[2] = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0,
                    2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0001};
        vecs[3] = '{2'b10, 32'h2000_0010, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'h0,
                    2'b10, 32'h2000_0010, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{2'b00, 32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001,
                    2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1111_0000};

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", 32'(HTRANS), 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_hready_m0", 32'(HREADY_M0), 32'h1);
        chk("rst_hready_m1", 32'(HREADY_M1), 32'h1);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            HTRANS_M0 = vecs[i].t0;
            HADDR_M0  = vecs[i].a0;
            HWRITE_M0 = vecs[i].w0;
            HTRANS_M1 = vecs[i].t1;
            HADDR_M1  = vecs[i].a1;
            HWRITE_M1 = vecs[i].w1;
            HREADY    = vecs[i].rdy;
            HRDATA    = vecs[i].rdata;
            @(negedge HCLK);
            chk($sformatf("v%0d_htrans", i), 32'(HTRANS), 32'(vecs[i].e_trans));
            chk($sformatf("v%0d_haddr", i), HADDR, vecs[i].e_addr);
            chk($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].e_write));
            chk($sformatf("v%0d_hready_m0", i), 32'(HREADY_M0), 32'(vecs[i].e_rdy0));
            chk($sformatf("v%0d_hready_m1", i), 32'(HREADY_M1), 32'(vecs[i].e_rdy1));
            chk($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].e_wdata);
            chk($sformatf("v%0d_hrdata_m0", i), HRDATA_M0, vecs[i].rdata);
            @(posedge HCLK);
            #1;
        end
        HRDATA = 32'h0;

        // Both masters stream bursts; last grant went to M0, so M1 leads and grants alternate.
        a0 = 32'h100;
        a1 = 32'h200;
        for (int k = 0; k < 8; k++) begin
            HTRANS_M0 = (a0 == 32'h100) ? 2'b10 : 2'b11;
            HTRANS_M1 = (a1 == 32'h200) ? 2'b10 : 2'b11;
            HADDR_M0  = a0;
            HADDR_M1  = a1;
            HWRITE_M0 = 1'b0;
            HWRITE_M1 = 1'b0;
            @(negedge HCLK);
            exp_addr = (k % 2 == 1) ? 32'h100 + 32'(4 * (k / 2)) : 32'h200 + 32'(4 * (k / 2));
            chk($sformatf("burst%0d_haddr", k), HADDR, exp_addr);
            chk($sformatf("burst%0d_htrans", k), 32'(HTRANS), 32'h2);
            r0 = HREADY_M0;
            r1 = HREADY_M1;
            @(posedge HCLK);
            #1;
            if (r0) a0 = a0 + 32'd4;
            if (r1) a1 = a1 + 32'd4;
        end

        // M1's 0x210 is now pending; reset before its replay is accepted drops it.
        set_idle();
        @(negedge HCLK);
        chk("pre_rst_hready_m1", 32'(HREADY_M1), 32'h0);
        chk("pre_rst_haddr", HADDR, 32'h210);
        HRESETn = 1'b0;
        @(negedge HCLK);
        chk("mid_rst_htrans", 32'(HTRANS), 32'h0);
        chk("mid_rst_hready_m0", 32'(HREADY_M0), 32'h1);
        chk("mid_rst_hready_m1", 32'(HREADY_M1), 32'h1);
        chk("mid_rst_hwdata", HWDATA, 32'h0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk($sformatf("post_rst%0d_htrans", k), 32'(HTRANS), 32'h0);
            chk($sformatf("post_rst%0d_hready_m1", k), 32'(HREADY_M1), 32'h1);
            @(posedge HCLK);
        end
        #1;

        // M1 write meets 3 wait-state cycles; the bus must hold its address throughout.
        HTRANS_M1 = 2'b10;
        HADDR_M1  = 32'h4900_0008;
        HWRITE_M1 = 1'b1;
        HWDATA_M1 = 32'h0;
        HREADY    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            HREADY = (k == 3);
            @(negedge HCLK);
            chk($sformatf("ws%0d_haddr", k), HADDR, 32'h4900_0008);
            chk($sformatf("ws%0d_htrans", k), 32'(HTRANS), 32'h2);
            chk($sformatf("ws%0d_hwrite", k), 32'(HWRITE), 32'h1);
            chk($sformatf("ws%0d_hsize", k), 32'(HSIZE), 32'h1);
            chk($sformatf("ws%0d_hready_m1", k), 32'(HREADY_M1), (k == 0) ? 32'h1 : 32'h0);
            chk($sformatf("ws%0d_hwdata", k), HWDATA, 32'h0);
            @(posedge HCLK);
            #1;
            if (k == 0) begin
                set_idle();
                HWDATA_M1 = 32'hDEAD_0001;
            end
        end
        @(negedge HCLK);
        chk("ws_data_hwdata", HWDATA, 32'hDEAD_0001);
        chk("ws_data_hready_m1", 32'(HREADY_M1), 32'h1);
        chk("ws_data_htrans", 32'(HTRANS), 32'h0);
        @(posedge HCLK);
        @(negedge HCLK);
        chk("ws_done_hready_m1", 32'(HREADY_M1), 32'h1);
        chk("ws_done_htrans", 32'(HTRANS), 32'h0);
        chk("ws_done_hwdata", HWDATA, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
